// File: rtl/tb_apb_arb.sv
// Round-robin APB master arbiter: serialises single read/write requests from
// NUM_REQ requesters onto one APB bus, with a wait-state timeout abort.
module tb_apb_arb #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      i_req,
    input  logic [NUM_REQ-1:0]      i_req_write,
    input  logic [NUM_REQ*32-1:0]   i_req_addr,
    input  logic [NUM_REQ*32-1:0]   i_req_wdata,
    output logic [NUM_REQ-1:0]      o_done,
    output logic                    o_err,
    output logic [31:0]             o_rdata,
    output logic                    o_psel,
    output logic                    o_penable,
    output logic                    o_pwrite,
    output logic [31:0]             o_paddr,
    output logic [31:0]             o_pwdata,
    input  logic [31:0]             i_prdata,
    input  logic                    i_pready
);

    localparam int          PTR_W        = $clog2(NUM_REQ);
    localparam int          CNT_W        = $clog2(TIMEOUT + 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   cur_idx;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand;
    logic               grant_valid;
    logic [CNT_W-1:0]   wait_cnt;
    logic               timeout_hit;
    logic               sel_write;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic [NUM_REQ-1:0] cur_onehot;

    // Round-robin search: first set request at or after rr_ptr+1, wrapping.
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr) + 1 + i) % NUM_REQ);
            if (!grant_valid && i_req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_write = i_req_write[i];
                sel_addr  = i_req_addr[32*i +: 32];
                sel_wdata = i_req_wdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        cur_onehot          = '0;
        cur_onehot[cur_idx] = 1'b1;
    end

    // The counter holds the number of already-elapsed wait cycles in ACCESS.
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (i_pready || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded from the async-reset state register, so they drop the instant rst rises.
    assign o_psel    = (state == SETUP) || (state == ACCESS);
    assign o_penable = (state == ACCESS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= PTR_W'(NUM_REQ - 1);
            cur_idx  <= '0;
            wait_cnt <= '0;
            o_pwrite <= 1'b0;
            o_paddr  <= '0;
            o_pwdata <= '0;
            o_done   <= '0;
            o_err    <= 1'b0;
            o_rdata  <= '0;
        end else begin
            o_done  <= '0;
            o_err   <= 1'b0;
            o_rdata <= '0;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        rr_ptr   <= grant_idx;
                        cur_idx  <= grant_idx;
                        o_pwrite <= sel_write;
                        o_paddr  <= sel_addr;
                        o_pwdata <= sel_wdata;
                    end
                end
                SETUP: begin
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    if (i_pready) begin
                        o_done  <= cur_onehot;
                        o_rdata <= o_pwrite ? 32'd0 : i_prdata;
                    end else if (timeout_hit) begin
                        o_done  <= cur_onehot;
                        o_err   <= 1'b1;
                        o_rdata <= TIMEOUT_DATA;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tb_apb_arb.sv
// Self-checking bench for tb_apb_arb: directed scenarios plus randomized
// traffic scored against a round-robin reference model.
module tb_tb_apb_arb;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req = '0;
    logic [NUM_REQ-1:0]    req_write = '0;
    logic [31:0]           addr_arr  [NUM_REQ];
    logic [31:0]           wdata_arr [NUM_REQ];
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    done;
    logic                  err;
    logic [31:0]           rdata;
    logic                  psel, penable, pwrite;
    logic [31:0]           paddr, pwdata;
    logic [31:0]           prdata;
    logic                  pready = 1'b0;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int proto_bad  = 0;

    // Slave behaviour knobs
    int          slave_wait  = 0;
    bit          never_ready = 1'b0;
    logic [31:0] slave_rdata = '0;
    int          acc_cnt     = 0;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign req_addr[32*g +: 32]  = addr_arr[g];
        assign req_wdata[32*g +: 32] = wdata_arr[g];
    end
    assign prdata = slave_rdata;

    tb_apb_arb #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req),
        .i_req_write (req_write),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_done      (done),
        .o_err       (err),
        .o_rdata     (rdata),
        .o_psel      (psel),
        .o_penable   (penable),
        .o_pwrite    (pwrite),
        .o_paddr     (paddr),
        .o_pwdata    (pwdata),
        .i_prdata    (prdata),
        .i_pready    (pready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Slave: ready after slave_wait wait states, or never.
    always @(negedge clk) begin
        if (psel && penable) begin
            acc_cnt++;
            pready = !never_ready && (acc_cnt >= slave_wait + 1);
        end else begin
            acc_cnt = 0;
            pready  = 1'b0;
        end
    end

    // Bus invariants watched continuously
    always @(negedge clk) begin
        if (penable && !psel) proto_bad++;
        if (psel && done != '0) proto_bad++;
        if (done != '0 && !$onehot(done)) proto_bad++;
        if (done == '0 && (err || rdata != 32'd0)) proto_bad++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_reqs();
        req       = '0;
        req_write = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            addr_arr[k]  = '0;
            wdata_arr[k] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        slave_wait  = 0;
        never_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic observe(input int budget, output int acc, output logic [NUM_REQ-1:0] dv,
                           output logic ev, output logic [31:0] rv, output int dcyc, output bit to);
        acc  = 0;
        dv   = '0;
        ev   = 1'b0;
        rv   = '0;
        dcyc = 0;
        to   = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (psel && penable) acc++;
            if (done != '0) begin
                dv   = done;
                ev   = err;
                rv   = rdata;
                dcyc = cyc;
                to   = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clear_reqs();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({psel, penable, pwrite, err} !== 4'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=0000", {psel, penable, pwrite, err});
        end
        checks++;
        if (done !== '0 || rdata !== '0) begin
            failures++; $display("FAIL reset_done got done=%b rdata=%h want 0/0", done, rdata);
        end
        checks++;
        if (paddr !== '0 || pwdata !== '0) begin
            failures++; $display("FAIL reset_bus got paddr=%h pwdata=%h want 0/0", paddr, pwdata);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (psel !== 1'b0 || done !== '0) begin
            failures++; $display("FAIL idle_no_req got psel=%b done=%b want 0/0", psel, done);
        end
    endtask

    task automatic test_single_write();
        clear_reqs();
        do_reset();
        @(negedge clk);
        slave_wait   = 0;
        req_write[0] = 1'b1;
        addr_arr[0]  = 32'h0000_0010;
        wdata_arr[0] = 32'h1234_5678;
        req[0]       = 1'b1;
        @(negedge clk);
        checks++;
        if ({psel, penable} !== 2'b10) begin
            failures++; $display("FAIL wr_setup got psel/penable=%b want 10", {psel, penable});
        end
        checks++;
        if (paddr !== 32'h10 || pwdata !== 32'h1234_5678 || pwrite !== 1'b1) begin
            failures++; $display("FAIL wr_fields got addr=%h data=%h wr=%b want 10/12345678/1", paddr, pwdata, pwrite);
        end
        @(negedge clk);
        checks++;
        if ({psel, penable} !== 2'b11) begin
            failures++; $display("FAIL wr_access got psel/penable=%b want 11", {psel, penable});
        end
        @(negedge clk);
        checks++;
        if (done !== 4'b0001 || err !== 1'b0 || rdata !== 32'd0 || psel !== 1'b0) begin
            failures++; $display("FAIL wr_done got done=%b err=%b rdata=%h psel=%b want 0001/0/0/0", done, err, rdata, psel);
        end
        req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== '0 || psel !== 1'b0) begin
            failures++; $display("FAIL wr_after got done=%b psel=%b want 0/0", done, psel);
        end
    endtask

    task automatic test_read_wait();
        int acc, dcyc;
        logic [NUM_REQ-1:0] dv;
        logic ev;
        logic [31:0] rv;
        bit to;
        clear_reqs();
        do_reset();
        @(negedge clk);
        slave_wait   = 3;
        slave_rdata  = 32'hCAFE_0001;
        addr_arr[2]  = 32'h0000_0004;
        req[2]       = 1'b1;
        observe(40, acc, dv, ev, rv, dcyc, to);
        checks++;
        if (to) begin failures++; $display("FAIL rd_wait_timeout got no done want done"); end
        checks++;
        if (acc !== 4) begin failures++; $display("FAIL rd_wait_access got=%0d want=4", acc); end
        checks++;
        if (dv !== 4'b0100 || ev !== 1'b0 || rv !== 32'hCAFE_0001) begin
            failures++; $display("FAIL rd_wait_done got done=%b err=%b rdata=%h want 0100/0/cafe0001", dv, ev, rv);
        end
        checks++;
        if (paddr !== 32'h4 || pwrite !== 1'b0) begin
            failures++; $display("FAIL rd_wait_hold got addr=%h wr=%b want 4/0", paddr, pwrite);
        end
        req[2] = 1'b0;
    endtask

    task automatic test_fairness();
        int acc, dcyc, prev_cyc;
        logic [NUM_REQ-1:0] dv, exp_dv;
        logic ev;
        logic [31:0] rv;
        bit to;
        clear_reqs();
        for (int k = 0; k < NUM_REQ; k++) addr_arr[k] = 32'h100 + 32'(4 * k);
        @(negedge clk);
        rst = 1'b1;
        req = '1;
        slave_wait = 0;
        @(negedge clk);
        rst = 1'b0;
        prev_cyc = 0;
        for (int n = 0; n < 6; n++) begin
            observe(20, acc, dv, ev, rv, dcyc, to);
            exp_dv = NUM_REQ'(1) << (n % NUM_REQ);
            checks++;
            if (to || dv !== exp_dv) begin
                failures++; $display("FAIL fair_grant%0d got=%b want=%b", n, dv, exp_dv);
            end
            if (n > 0) begin
                checks++;
                if (dcyc - prev_cyc !== 4) begin
                    failures++; $display("FAIL fair_spacing%0d got=%0d want=4", n, dcyc - prev_cyc);
                end
            end
            prev_cyc = dcyc;
        end
        req = '0;
    endtask

    task automatic test_timeout();
        int acc, dcyc;
        logic [NUM_REQ-1:0] dv;
        logic ev;
        logic [31:0] rv;
        bit to;
        clear_reqs();
        do_reset();
        @(negedge clk);
        never_ready  = 1'b1;
        req_write[1] = 1'b1;
        addr_arr[1]  = 32'h0000_0020;
        wdata_arr[1] = 32'h5555_AAAA;
        req[1]       = 1'b1;
        observe(60, acc, dv, ev, rv, dcyc, to);
        checks++;
        if (to || acc !== TIMEOUT) begin
            failures++; $display("FAIL to_access got=%0d want=%0d", acc, TIMEOUT);
        end
        checks++;
        if (dv !== 4'b0010 || ev !== 1'b1 || rv !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL to_done got done=%b err=%b rdata=%h want 0010/1/deadbeef", dv, ev, rv);
        end
        req[1]      = 1'b0;
        never_ready = 1'b0;
        slave_wait  = 0;
        slave_rdata = $urandom;
        addr_arr[3] = 32'h0000_0030;
        req[3]      = 1'b1;
        observe(20, acc, dv, ev, rv, dcyc, to);
        checks++;
        if (to || dv !== 4'b1000 || ev !== 1'b0 || rv !== slave_rdata) begin
            failures++; $display("FAIL to_recover got done=%b err=%b rdata=%h want 1000/0/%h", dv, ev, rv, slave_rdata);
        end
        req[3] = 1'b0;
    endtask

    task automatic test_ready_at_limit();
        int acc, dcyc;
        logic [NUM_REQ-1:0] dv;
        logic ev;
        logic [31:0] rv;
        bit to;
        clear_reqs();
        do_reset();
        @(negedge clk);
        slave_wait  = TIMEOUT - 1;
        slave_rdata = $urandom;
        addr_arr[0] = 32'h0000_0040;
        req[0]      = 1'b1;
        observe(60, acc, dv, ev, rv, dcyc, to);
        checks++;
        if (to || acc !== TIMEOUT) begin
            failures++; $display("FAIL limit_access got=%0d want=%0d", acc, TIMEOUT);
        end
        checks++;
        if (dv !== 4'b0001 || ev !== 1'b0 || rv !== slave_rdata) begin
            failures++; $display("FAIL limit_done got done=%b err=%b rdata=%h want 0001/0/%h", dv, ev, rv, slave_rdata);
        end
        req[0] = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int acc, dcyc;
        logic [NUM_REQ-1:0] dv;
        logic ev;
        logic [31:0] rv;
        bit to;
        bit reached;
        clear_reqs();
        do_reset();
        @(negedge clk);
        never_ready = 1'b1;
        addr_arr[1] = 32'h0000_0050;
        req[1]      = 1'b1;
        reached     = 1'b0;
        for (int c = 0; c < 10 && !reached; c++) begin
            @(negedge clk);
            if (psel && penable) reached = 1'b1;
        end
        checks++;
        if (!reached) begin failures++; $display("FAIL rst_mid_reach got no ACCESS want ACCESS"); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            failures++; $display("FAIL rst_mid_drop got psel=%b penable=%b want 0/0", psel, penable);
        end
        never_ready = 1'b0;
        slave_wait  = 0;
        slave_rdata = $urandom;
        addr_arr[0] = 32'h0000_0060;
        req         = 4'b0011;
        @(negedge clk);
        checks++;
        if (done !== '0) begin failures++; $display("FAIL rst_mid_nodone got=%b want=0000", done); end
        rst = 1'b0;
        observe(20, acc, dv, ev, rv, dcyc, to);
        checks++;
        if (to || dv !== 4'b0001 || rv !== slave_rdata) begin
            failures++; $display("FAIL rst_mid_first got done=%b rdata=%h want 0001/%h", dv, rv, slave_rdata);
        end
        req[0] = 1'b0;
        observe(20, acc, dv, ev, rv, dcyc, to);
        checks++;
        if (to || dv !== 4'b0010 || paddr !== 32'h50) begin
            failures++; $display("FAIL rst_mid_second got done=%b addr=%h want 0010/50", dv, paddr);
        end
        req[1] = 1'b0;
    endtask

    // Reference: pending set is req; winner is first pending after last winner.
    task automatic test_random();
        int acc, dcyc, w, last, k;
        logic [NUM_REQ-1:0] dv;
        logic ev;
        logic [31:0] rv, exp_rv;
        bit to;
        clear_reqs();
        do_reset();
        @(negedge clk);
        last = NUM_REQ - 1;
        for (int r = 0; r < 40; r++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!req[j] && $urandom_range(0, 1) == 1) begin
                    req_write[j] = 1'($urandom_range(0, 1));
                    addr_arr[j]  = $urandom;
                    wdata_arr[j] = $urandom;
                    req[j]       = 1'b1;
                end
            end
            if (req == '0) begin
                k = $urandom_range(0, NUM_REQ - 1);
                req_write[k] = 1'($urandom_range(0, 1));
                addr_arr[k]  = $urandom;
                wdata_arr[k] = $urandom;
                req[k]       = 1'b1;
            end
            w = -1;
            for (int i = 1; i <= NUM_REQ; i++) begin
                k = (last + i) % NUM_REQ;
                if (w < 0 && req[k]) w = k;
            end
            slave_wait  = $urandom_range(0, 5);
            slave_rdata = $urandom;
            exp_rv      = req_write[w] ? 32'd0 : slave_rdata;
            observe(40, acc, dv, ev, rv, dcyc, to);
            checks++;
            if (to || dv !== (NUM_REQ'(1) << w) || ev !== 1'b0) begin
                failures++; $display("FAIL rand%0d_grant got done=%b err=%b want %b/0", r, dv, ev, NUM_REQ'(1) << w);
            end
            checks++;
            if (rv !== exp_rv || acc !== slave_wait + 1) begin
                failures++; $display("FAIL rand%0d_data got rdata=%h acc=%0d want %h/%0d", r, rv, acc, exp_rv, slave_wait + 1);
            end
            checks++;
            if (paddr !== addr_arr[w] || pwrite !== req_write[w] || pwdata !== wdata_arr[w]) begin
                failures++; $display("FAIL rand%0d_bus got addr=%h wr=%b data=%h want %h/%b/%h",
                                     r, paddr, pwrite, pwdata, addr_arr[w], req_write[w], wdata_arr[w]);
            end
            req[w] = 1'b0;
            last   = w;
        end
        req = '0;
    endtask

    task automatic test_protocol();
        checks++;
        if (proto_bad !== 0) begin
            failures++; $display("FAIL bus_invariants got violations=%0d want=0", proto_bad);
        end
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_single_write();
        test_read_wait();
        test_fairness();
        test_timeout();
        test_ready_at_limit();
        test_reset_mid_access();
        test_random();
        repeat (2) @(negedge clk);
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tb_apb_arb.md
# tb_apb_arb

Round-robin APB master arbiter for the unit-test register benches. It accepts single read/write requests from NUM_REQ independent requesters (sequence drivers, update pollers, backdoor checkers) and serialises them onto one APB bus that drives a register-update model. It also returns read data and a per-transfer completion/error status to the winning requester. A wait-state timeout turns a hung slave into an error completion instead of a stalled bench.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters, 2..8.
- TIMEOUT, 16, consecutive ACCESS cycles with i_pready low before abort, 2..255.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- i_req  input  NUM_REQ  per-requester request; held high with its fields stable until its o_done bit pulses.
- i_req_write  input  NUM_REQ  1 = write, 0 = read.
- i_req_addr  input  NUM_REQ*32  packed addresses; requester k at bits [32k+31:32k].
- i_req_wdata  input  NUM_REQ*32  packed write data, same packing.
- o_done  output  NUM_REQ  one-cycle one-hot completion pulse.
- o_err  output  1  valid with o_done; 1 = timeout abort.
- o_rdata  output  32  valid with o_done. Holds read data, 32'hDEAD_BEEF on timeout, 0 for writes.
- o_psel, o_penable, o_pwrite  output  1 each  APB control.
- o_paddr, o_pwdata  output  32 each  APB address and write data.
- i_prdata  input  32  APB read data.
- i_pready  input  1  APB ready.

## Operation
- FSM states:
  - IDLE: arbitrate. Any i_req high moves to SETUP with the winner latched. None high stays in IDLE.
  - SETUP: o_psel=1, o_penable=0. Always moves to ACCESS.
  - ACCESS: o_psel=1, o_penable=1.
    - i_pready=1 moves to DONE with i_prdata captured on reads.
    - Otherwise the wait counter increments. Reaching TIMEOUT moves to DONE with the error flag set.
  - DONE: o_psel=0; o_done[winner]=1, o_err and o_rdata driven. Always moves to IDLE.
- Arbitration is round-robin:
  - The search starts at (last winner + 1) mod NUM_REQ and picks the first set i_req bit.
  - After reset the pointer is such that requester 0 has highest priority.
  - The pointer updates only when a winner is latched in IDLE.
- Latching: o_pwrite, o_paddr and o_pwdata are registered from the winner's fields on IDLE->SETUP. They hold constant through ACCESS and DONE, and change only at the next IDLE->SETUP.
- Request arrival in SETUP/ACCESS/DONE is not arbitrated until the next IDLE. A requester that drops i_req before its o_done is a protocol violation; the transfer still completes.
- No arbitration occurs in DONE, so a requester releasing i_req in response to o_done is never re-granted for the same request.
- Wait counter: width $clog2(TIMEOUT+1). It clears on entering ACCESS and never wraps.
- Reset mid-transfer aborts immediately: APB outputs drop asynchronously, no o_done is issued, and the requester must re-request.

## Timing
- Reset values: all outputs 0, FSM IDLE, RR pointer = NUM_REQ-1, wait counter 0.
- Zero-wait transfer: i_req seen in IDLE at cycle 0 gives SETUP in cycle 1, ACCESS in cycle 2 (i_pready=1), and o_done in cycle 3. Latency from i_req to o_done is 3 cycles.
- Back-to-back requests: 4 cycles per transfer (IDLE, SETUP, ACCESS, DONE); the next SETUP can occur at cycle 5.
- Each wait state (i_pready=0 in ACCESS) adds one cycle.
- Timeout: if ACCESS lasts TIMEOUT cycles with i_pready low throughout, DONE follows with o_err=1. i_pready=1 in the last counted cycle wins over the timeout, giving no error.
- o_done, o_err and o_rdata are registered, high for exactly one cycle, and 0 outside DONE.
- o_penable is never high without o_psel; o_psel is high only in SETUP and ACCESS.

## Test plan
- Single write: req0 writes 0x1234_5678 to 0x0000_0010 with zero-wait slave.
  - Expected: SETUP in cycle 1, ACCESS in cycle 2, o_done=4'b0001 in cycle 3, o_err=0, o_rdata=0.
- Read with 3 wait states: req2 reads 0x0000_0004 and the slave returns 0xCAFE_0001.
  - Expected: ACCESS lasts 4 cycles, o_done=4'b0100, o_rdata=0xCAFE_0001.
- Fairness: all four i_req held high continuously from reset.
  - Expected: grants in order 0,1,2,3,0,1, each transfer 4 cycles apart, with no requester granted twice in a row.
- Timeout (TIMEOUT=16): slave never asserts i_pready.
  - Expected: exactly 16 ACCESS cycles, then o_err=1 and o_rdata=0xDEAD_BEEF, after which the bus returns to IDLE and serves the next request.
- Ready at limit: i_pready rises in the 16th ACCESS cycle.
  - Expected: o_err=0 and o_rdata = i_prdata.
- Reset mid-ACCESS: assert rst for 1 cycle during a wait state.
  - Expected: o_psel/o_penable drop in the same cycle, no o_done pulses, and after release req0 is served first.
